// File: rtl/target_timer_array.sv
// Multi-channel time-of-arrival counter: one counter per sensor channel, started by its own
// trigger, with a shared stop, quiet gate, arm/done sequencing and a timeout watchdog.
module target_timer_array #(
    parameter int unsigned  NCH       = 4,
    parameter int unsigned  WIDTH     = 16,
    parameter int unsigned  TW        = 16,
    parameter int unsigned  TIMEOUT   = 50000,
    parameter bit           AUTO_STOP = 1'b1,
    localparam int unsigned CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [NCH-1:0]       start,
    input  logic                 stop,
    input  logic                 quiet,
    output logic                 armed,
    output logic                 busy,
    output logic                 done,
    output logic [NCH-1:0]       hit,
    output logic [NCH-1:0]       ovf,
    output logic                 timeout,
    output logic [CW-1:0]        first_ch,
    output logic [NCH*WIDTH-1:0] count
);
    typedef enum logic [1:0] {StIdle, StArmed, StRunning, StDone} state_e;

    state_e           state_q;
    logic             armed_q, busy_q, done_q, timeout_q;
    logic [NCH-1:0]   hit_q, ovf_q;
    logic [CW-1:0]    first_q;
    logic [TW-1:0]    elapsed_q;
    logic [WIDTH-1:0] cnt_q [NCH];

    logic             clear_res;
    logic [CW-1:0]    first_idx;
    logic [TW:0]      elapsed_inc;
    logic             wd_expire;

    // Lowest set start bit wins when several channels trigger on the same edge.
    always_comb begin
        first_idx = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (start[i]) first_idx = CW'(i);
        end
    end

    always_comb begin
        clear_res   = abort | (arm & ((state_q == StIdle) | (state_q == StDone)));
        elapsed_inc = {1'b0, elapsed_q} + 1'b1;
        wd_expire   = (elapsed_inc == (TW + 1)'(TIMEOUT));
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= StIdle;
            armed_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            hit_q     <= '0;
            ovf_q     <= '0;
            first_q   <= '0;
            elapsed_q <= '0;
            for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= '0;
        end else if (clear_res) begin
            // abort returns to idle; arm from idle/done re-arms; both wipe the results
            state_q   <= abort ? StIdle : StArmed;
            armed_q   <= ~abort;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            hit_q     <= '0;
            ovf_q     <= '0;
            first_q   <= '0;
            elapsed_q <= '0;
            for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: ;
                StArmed: begin
                    if (|start) begin
                        state_q <= StRunning;
                        armed_q <= 1'b0;
                        busy_q  <= 1'b1;
                        hit_q   <= start;
                        first_q <= first_idx;
                    end
                end
                StRunning: begin
                    elapsed_q <= elapsed_q + 1'b1;
                    // Counting uses the hit vector from before this edge, so the exit edge counts.
                    for (int i = 0; i < int'(NCH); i++) begin
                        if (hit_q[i] && !quiet) begin
                            if (&cnt_q[i]) ovf_q[i] <= 1'b1;
                            else           cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                    if (!stop) hit_q <= hit_q | start;
                    if (stop) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (wd_expire) begin
                        state_q   <= StDone;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else if (AUTO_STOP && (&hit_q)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < int'(NCH); i++) count[i*WIDTH +: WIDTH] = cnt_q[i];
    end

    assign armed    = armed_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign hit      = hit_q;
    assign ovf      = ovf_q;
    assign timeout  = timeout_q;
    assign first_ch = first_q;

endmodule

// File: tb/tb_target_timer_array.sv
// Bench for target_timer_array: three parameterisations share one stimulus stream and are
// compared every cycle against a behavioural model, plus hand-computed expectations.
module tb_target_timer_array;
    localparam int NI = 3;
    localparam int S_IDLE = 0, S_ARMED = 1, S_RUN = 2, S_DONE = 3;

    // instance 0: WIDTH 16, TIMEOUT 200, auto-stop; 1: WIDTH 4, TIMEOUT 50; 2: WIDTH 16, TIMEOUT 50
    int w_tab[NI]    = '{16, 4, 16};
    int lim_tab[NI]  = '{200, 50, 50};
    int auto_tab[NI] = '{1, 0, 0};

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       arm, abort, stop, quiet;
    logic [3:0] start;

    logic       o_armed [NI];
    logic       o_busy [NI];
    logic       o_done [NI];
    logic [3:0] o_hit [NI];
    logic [3:0] o_ovf [NI];
    logic       o_tmo [NI];
    logic [1:0] o_first [NI];
    logic [63:0] o_count [NI];
    logic [63:0] a_count, c_count;
    logic [15:0] b_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    target_timer_array #(.NCH(4), .WIDTH(16), .TW(16), .TIMEOUT(200), .AUTO_STOP(1'b1)) u_a (
        .clk(clk), .clr(clr), .arm(arm), .abort(abort), .start(start), .stop(stop),
        .quiet(quiet), .armed(o_armed[0]), .busy(o_busy[0]), .done(o_done[0]), .hit(o_hit[0]),
        .ovf(o_ovf[0]), .timeout(o_tmo[0]), .first_ch(o_first[0]), .count(a_count)
    );
    target_timer_array #(.NCH(4), .WIDTH(4), .TW(16), .TIMEOUT(50), .AUTO_STOP(1'b0)) u_b (
        .clk(clk), .clr(clr), .arm(arm), .abort(abort), .start(start), .stop(stop),
        .quiet(quiet), .armed(o_armed[1]), .busy(o_busy[1]), .done(o_done[1]), .hit(o_hit[1]),
        .ovf(o_ovf[1]), .timeout(o_tmo[1]), .first_ch(o_first[1]), .count(b_count)
    );
    target_timer_array #(.NCH(4), .WIDTH(16), .TW(16), .TIMEOUT(50), .AUTO_STOP(1'b0)) u_c (
        .clk(clk), .clr(clr), .arm(arm), .abort(abort), .start(start), .stop(stop),
        .quiet(quiet), .armed(o_armed[2]), .busy(o_busy[2]), .done(o_done[2]), .hit(o_hit[2]),
        .ovf(o_ovf[2]), .timeout(o_tmo[2]), .first_ch(o_first[2]), .count(c_count)
    );

    assign o_count[0] = a_count;
    assign o_count[1] = {48'd0, b_count};
    assign o_count[2] = c_count;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint chan(input logic [63:0] bus, input int w, input int ch);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return longint'((bus >> (ch * w)) & mask);
    endfunction

    function automatic int lowest(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) return i;
        return 0;
    endfunction

    // Behavioural model: state as a small integer, counts as plain ints.
    int         m_st [NI];
    int         m_cnt [NI][4];
    logic [3:0] m_hit [NI];
    logic [3:0] m_ovf [NI];
    logic       m_tmo [NI];
    int         m_first [NI];
    int         m_el [NI];

    task automatic m_clear(input int k);
        for (int ch = 0; ch < 4; ch++) m_cnt[k][ch] = 0;
        m_hit[k] = 4'b0; m_ovf[k] = 4'b0; m_tmo[k] = 1'b0; m_first[k] = 0; m_el[k] = 0;
    endtask

    always @(posedge clk or posedge clr) begin
        for (int k = 0; k < NI; k++) begin
            if (clr || abort) begin
                m_clear(k);
                m_st[k] = S_IDLE;
            end else if (m_st[k] == S_IDLE || m_st[k] == S_DONE) begin
                if (arm) begin
                    m_clear(k);
                    m_st[k] = S_ARMED;
                end
            end else if (m_st[k] == S_ARMED) begin
                if (start != 4'b0) begin
                    m_hit[k] = start;
                    m_first[k] = lowest(start);
                    m_st[k] = S_RUN;
                end
            end else begin
                for (int ch = 0; ch < 4; ch++) begin
                    if (m_hit[k][ch] && !quiet) begin
                        if (m_cnt[k][ch] == (1 << w_tab[k]) - 1) m_ovf[k][ch] = 1'b1;
                        else m_cnt[k][ch] = m_cnt[k][ch] + 1;
                    end
                end
                m_el[k] = m_el[k] + 1;
                if (stop) m_st[k] = S_DONE;
                else if (m_el[k] == lim_tab[k]) begin
                    m_st[k] = S_DONE;
                    m_tmo[k] = 1'b1;
                end else if (auto_tab[k] != 0 && m_hit[k] == 4'hF) m_st[k] = S_DONE;
                if (!stop) m_hit[k] = m_hit[k] | start;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("i%0d armed", k), o_armed[k], m_st[k] == S_ARMED);
                chk($sformatf("i%0d busy", k), o_busy[k], m_st[k] == S_RUN);
                chk($sformatf("i%0d done", k), o_done[k], m_st[k] == S_DONE);
                chk($sformatf("i%0d hit", k), o_hit[k], m_hit[k]);
                chk($sformatf("i%0d ovf", k), o_ovf[k], m_ovf[k]);
                chk($sformatf("i%0d timeout", k), o_tmo[k], m_tmo[k]);
                chk($sformatf("i%0d first_ch", k), o_first[k], m_first[k]);
                for (int ch = 0; ch < 4; ch++)
                    chk($sformatf("i%0d count%0d", k, ch), chan(o_count[k], w_tab[k], ch),
                        m_cnt[k][ch]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Edges 0..n; channel ch pulses start at edge t_ch (-1: never); stop at stop_at.
    task automatic run(input int n, input int stop_at, input int q_lo, input int q_hi,
                       input int t0, input int t1, input int t2, input int t3);
        int t[4];
        t = '{t0, t1, t2, t3};
        for (int e = 0; e <= n; e++) begin
            for (int ch = 0; ch < 4; ch++) start[ch] = (t[ch] == e);
            stop  = (e == stop_at);
            quiet = (e >= q_lo && e <= q_hi);
            cyc();
        end
        start = 4'b0; stop = 1'b0; quiet = 1'b0;
    endtask

    initial begin
        arm = 1'b0; abort = 1'b0; start = 4'b0; stop = 1'b0; quiet = 1'b0;
        #1 clr = 1'b1;
        repeat (2) cyc();
        chk_en = 1'b1;
        chk("rst done", o_done[0], 0);
        chk("rst armed", o_armed[0], 0);
        chk("rst count", a_count, 0);
        clr = 1'b0;

        // basic run
        arm = 1'b1; cyc(); arm = 1'b0;
        chk("arm armed", o_armed[0], 1);
        run(100, 100, -1, -1, 10, 25, 0, -1);
        chk("basic done", o_done[0], 1);
        chk("basic ch0", chan(a_count, 16, 0), 90);
        chk("basic ch1", chan(a_count, 16, 1), 75);
        chk("basic ch2", chan(a_count, 16, 2), 100);
        chk("basic ch3", chan(a_count, 16, 3), 0);
        chk("basic hit", o_hit[0], 4'b0111);
        chk("basic first", o_first[0], 2);
        chk("basic timeout", o_tmo[0], 0);

        // quiet gating over edges 41..60
        arm = 1'b1; cyc(); arm = 1'b0;
        run(100, 100, 41, 60, 10, 25, 0, -1);
        chk("quiet ch0", chan(a_count, 16, 0), 70);
        chk("quiet ch1", chan(a_count, 16, 1), 55);
        chk("quiet ch2", chan(a_count, 16, 2), 80);
        chk("quiet ch3", chan(a_count, 16, 3), 0);

        // saturation on the 4-bit instance
        arm = 1'b1; cyc(); arm = 1'b0;
        run(30, 30, -1, -1, 0, -1, -1, -1);
        chk("sat b ch0", chan(o_count[1], 4, 0), 15);
        chk("sat b ovf", o_ovf[1], 4'b0001);
        chk("sat a ch0", chan(a_count, 16, 0), 30);
        arm = 1'b1; cyc(); arm = 1'b0;
        chk("rearm b ch0", chan(o_count[1], 4, 0), 0);
        chk("rearm b ovf", o_ovf[1], 0);
        chk("rearm b armed", o_armed[1], 1);

        // watchdog timeout on instance 2 (TIMEOUT 50)
        run(60, -1, -1, -1, -1, 0, -1, -1);
        chk("tmo c done", o_done[2], 1);
        chk("tmo c flag", o_tmo[2], 1);
        chk("tmo c ch1", chan(c_count, 16, 1), 50);
        chk("tmo c hit", o_hit[2], 4'b0010);
        chk("tmo a busy", o_busy[0], 1);
        stop = 1'b1; cyc(); stop = 1'b0;

        // simultaneous start with auto-stop
        arm = 1'b1; cyc(); arm = 1'b0;
        run(1, -1, -1, -1, 0, 0, 0, 0);
        chk("sim first", o_first[0], 0);
        chk("sim hit", o_hit[0], 4'hF);
        chk("sim done", o_done[0], 1);
        chk("sim counts", a_count, 64'h0001_0001_0001_0001);
        chk("sim b busy", o_busy[1], 1);
        stop = 1'b1; cyc(); stop = 1'b0;
        arm = 1'b1; cyc(); arm = 1'b0;
        start = 4'b1001; cyc(); start = 4'b0;
        chk("sim9 first", o_first[0], 0);
        chk("sim9 busy", o_busy[0], 1);
        stop = 1'b1; cyc(); stop = 1'b0;

        // stop in ARMED and arm in RUNNING are ignored; abort from DONE
        arm = 1'b1; cyc(); arm = 1'b0;
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("stop armed", o_armed[0], 1);
        start = 4'b0100; cyc(); start = 4'b0;
        arm = 1'b1; cyc(); arm = 1'b0;
        chk("arm running", o_busy[0], 1);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("pre-abort done", o_done[0], 1);
        chk("pre-abort ch2", chan(a_count, 16, 2), 2);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("abort done", o_done[0], 0);
        chk("abort armed", o_armed[0], 0);
        chk("abort count", a_count, 0);

        // asynchronous clear mid-run, checked before any further clock edge
        arm = 1'b1; cyc(); arm = 1'b0;
        start = 4'b0001; cyc(); start = 4'b0;
        repeat (5) cyc();
        chk("pre-clr ch0", chan(a_count, 16, 0), 5);
        #2 clr = 1'b1;
        #1;
        chk("clr busy", o_busy[0], 0);
        chk("clr count", a_count, 0);
        chk("clr hit", o_hit[0], 0);
        cyc();
        clr = 1'b0;
        repeat (3) cyc();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/target_timer_array.md
Name: target_timer_array

Overview:
- Multi-channel time-of-arrival counter for the acoustic target front end; successor to the single-channel mic counter.
- One counter per sensor channel, started by that channel's trigger.
- All channels share a global stop, a quiet gate, an arm/done sequencing FSM and a timeout watchdog.
- Sits between the synchronised mic comparator inputs and the readout/host interface; results are frozen in DONE until re-armed.

Parameters:
- NCH, 4, number of sensor channels (>=2).
- WIDTH, 16, per-channel counter width.
- TW, 16, elapsed/timeout counter width.
- TIMEOUT, 50000, RUNNING cycles before forced DONE (1..2^TW-1).
- AUTO_STOP, 1, go DONE once every channel has triggered.

Ports:
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-high
- arm  in  1  arm request (synchronous pulse/level)
- abort  in  1  synchronous return to IDLE, clears results
- start  in  NCH  per-channel trigger, synchronous, active-high
- stop  in  1  global stop, active-high
- quiet  in  1  counting inhibit while high
- armed  out  1  state==ARMED
- busy  out  1  state==RUNNING
- done  out  1  state==DONE
- hit  out  NCH  sticky: channel has triggered
- ovf  out  NCH  sticky: channel counter saturated
- timeout  out  1  sticky: DONE caused by watchdog
- first_ch  out  max(1,$clog2(NCH))  index of first channel to trigger
- count  out  NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]

Behaviour:
- Reset (clr high): immediately IDLE; all outputs, counters, elapsed and hit/ovf/timeout/first_ch are 0. Applies mid-operation.
- FSM states: IDLE, ARMED, RUNNING, DONE. Registered outputs are decoded from state.
- abort has the highest priority in every state: next edge goes to IDLE with full clear.
- IDLE: arm -> ARMED, clearing results. start and stop are ignored.
- DONE: arm -> ARMED, clearing counts, hit, ovf, timeout, first_ch and elapsed. Otherwise all results hold.
- ARMED and RUNNING: arm is ignored.
- ARMED:
  - Any start bit high -> RUNNING at that edge.
  - Every channel with start high sets hit[i] at that edge.
  - first_ch = lowest set index among those start bits.
  - stop is ignored in ARMED.
- RUNNING, per edge, in priority order:
  1. stop -> DONE. Channels whose start rises on this edge do not set hit.
  2. elapsed+1 == TIMEOUT -> DONE, timeout=1.
  3. AUTO_STOP and hit all-ones -> DONE.
  4. Otherwise stay.
  - Unstopped: any start[i] with hit[i]=0 sets hit[i]. first_ch is not updated after ARMED.
- elapsed: increments on every edge taken in RUNNING, independent of quiet. Holds in DONE; cleared on arm.
- Count rule:
  - count[i] increments on an edge iff state==RUNNING before the edge, hit[i]=1 before the edge, and quiet=0.
  - This includes the edge leaving RUNNING.
  - A channel therefore reads 1 on the edge after its trigger.
- Saturation: at 2^WIDTH-1 the count holds. ovf[i] sets on the first edge where an increment would have occurred at the maximum value.
- Latency: trigger to hit = 1 edge; stop to done = 1 edge; counts are final and stable when done=1.
- Inputs are assumed already synchronised to clk.

Test Plan:
- Basic run (NCH=4, WIDTH=16): arm; start[2] at edge 0, start[0] at edge 10, start[1] at edge 25; stop sampled at edge 100 -> done=1, counts {ch0=90, ch1=75, ch2=100, ch3=0}, hit=4'b0111, first_ch=2, timeout=0.
- Quiet gating: as basic run, but quiet high for edges 41..60 -> ch0=70, ch1=55, ch2=80, ch3=0; elapsed=100.
- Saturation (WIDTH=4): start[0], stop at edge 30 -> count0=15, ovf=4'b0001; re-arm -> count0=0, ovf=0, armed=1.
- Timeout (TIMEOUT=50, AUTO_STOP=0): start[1] only, no stop -> done at edge 50, timeout=1, count1=50, hit=4'b0010.
- Simultaneous start (AUTO_STOP=1): start=4'b1111 at edge 0 -> first_ch=0, hit=4'b1111, DONE at edge 1, all counts=1. Separately, start=4'b1001 -> first_ch=0.
- Reset/abort: assert clr asynchronously mid-RUNNING -> outputs 0 with no clock edge. Separately, abort in DONE -> IDLE next edge with counts cleared. Also: stop in ARMED and arm in RUNNING are both ignored.
